// File: rtl/led_count_expand_if.sv
// LED beat stream between the expander and its consumer.
// master: led_v, ledBin_o, ledIndex_o out, led_ready in.
interface led_count_expand_if #(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12
);
  logic                       led_v;
  logic                       led_ready;
  logic [$clog2(BIN_QTY)-1:0] ledBin_o;
  logic [$clog2(LEDS)-1:0]    ledIndex_o;

  modport master (
    output led_v,
    output ledBin_o,
    output ledIndex_o,
    input  led_ready
  );

  modport slave (
    input  led_v,
    input  ledBin_o,
    input  ledIndex_o,
    output led_ready
  );
endinterface

// File: rtl/led_count_expand.sv
// Expands per-bin LED counts into a stream of exactly LEDS beats.
// clk/rst, LEDCount_i+data_v in, busy/frame_done/overflow out, led stream.
module led_count_expand #(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic [BIN_QTY-1:0][$clog2(LEDS)-1:0] LEDCount_i,
  input  logic data_v,
  output logic busy,
  output logic frame_done,
  output logic overflow,
  led_count_expand_if.master led
);
  localparam int CW = $clog2(LEDS);
  localparam int BW = $clog2(BIN_QTY);
  localparam int SW = CW + BW;
  localparam int RW = $clog2(LEDS + 1);

  localparam logic [SW-1:0] LEDS_S = SW'(LEDS);
  localparam logic [CW-1:0] LASTI  = CW'(LEDS - 1);
  localparam logic [BW-1:0] LASTB  = BW'(BIN_QTY - 1);

  typedef logic [BIN_QTY-1:0][CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  cnt_t            cnt_q, cnt_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [BW-1:0]   mbin_q, mbin_d;
  logic [CW-1:0]   mcnt_q, mcnt_d;
  logic [RW-1:0]   pad_q, pad_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            ovf_q, ovf_d;

  logic [CW-1:0]   c_cur;
  logic [SW-1:0]   s_new;
  logic            new_max;
  logic [BW-1:0]   mb_new;
  logic [CW-1:0]   mc_new;
  logic [RW-1:0]   pad_new;
  logic [BW-1:0]   bin_nx;
  logic            led_v;
  logic            xfer;
  logic            capture;

  // Effective count: the max bin absorbs any deficit.
  function automatic logic [RW-1:0] eff(
    input cnt_t          c,
    input logic [BW-1:0] b,
    input logic [BW-1:0] m,
    input logic [RW-1:0] p
  );
    logic [RW-1:0] e;
    e = RW'(c[b]);
    if (b == m) e = e + p;
    return e;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    sum_d   = sum_q;
    mbin_d  = mbin_q;
    mcnt_d  = mcnt_q;
    pad_d   = pad_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;

    c_cur   = cnt_q[bin_q];
    s_new   = sum_q + SW'(c_cur);
    // Strictly greater keeps ties on the lowest bin.
    new_max = c_cur > mcnt_q;
    mb_new  = new_max ? bin_q : mbin_q;
    mc_new  = new_max ? c_cur : mcnt_q;
    pad_new = (s_new < LEDS_S) ? RW'(LEDS_S - s_new) : '0;
    bin_nx  = (bin_q == LASTB) ? '0 : bin_q + BW'(1);

    led_v   = (state_q == EMIT) && (rem_q != '0);
    xfer    = led_v && led.led_ready;
    capture = data_v &&
              ((state_q == IDLE) || (state_q == DONE));

    unique case (state_q)
      IDLE, DONE: begin
        if (capture) begin
          state_d = SCAN;
          cnt_d   = LEDCount_i;
          bin_d   = '0;
          sum_d   = '0;
          mbin_d  = '0;
          mcnt_d  = '0;
          pad_d   = '0;
          rem_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        sum_d  = s_new;
        mbin_d = mb_new;
        mcnt_d = mc_new;
        bin_d  = bin_nx;
        if (bin_q == LASTB) begin
          ovf_d   = s_new > LEDS_S;
          pad_d   = pad_new;
          bin_d   = '0;
          rem_d   = eff(cnt_q, '0, mb_new, pad_new);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rem_q == '0) begin
          // Empty bin: one idle cycle, then move on.
          bin_d = bin_nx;
          rem_d = eff(cnt_q, bin_nx, mbin_q, pad_q);
        end else if (xfer) begin
          if (idx_q == LASTI) begin
            state_d = DONE;
            idx_d   = '0;
            rem_d   = '0;
            bin_d   = '0;
          end else begin
            idx_d = idx_q + CW'(1);
            if (rem_q == RW'(1)) begin
              // Preload next bin so beats stay back-to-back.
              bin_d = bin_nx;
              rem_d = eff(cnt_q, bin_nx, mbin_q, pad_q);
            end else begin
              rem_d = rem_q - RW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      sum_q   <= '0;
      mbin_q  <= '0;
      mcnt_q  <= '0;
      pad_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      sum_q   <= sum_d;
      mbin_q  <= mbin_d;
      mcnt_q  <= mcnt_d;
      pad_q   <= pad_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy           = (state_q == SCAN) || (state_q == EMIT);
  assign frame_done     = state_q == DONE;
  assign overflow       = ovf_q;
  assign led.led_v      = led_v;
  assign led.ledBin_o   = bin_q;
  assign led.ledIndex_o = idx_q;
endmodule
